// File: rtl/histo_readout.sv
// Snapshots the channel counters and interval bins on start, then streams them as a byte frame
// (A5, count, words LSB-first, XOR checksum). CLEAR_ON_READ_EN adds a one-cycle resethist pulse after the frame.
module histo_readout #(
  parameter int NBINS = 64,
  parameter int WIDTH = 32
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*WIDTH-1:0]     histo_in,
  input  logic [NBINS*WIDTH-1:0] ipihist_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   resethist,
  output logic [2:0]             dbg_state
);

  // Handshake: a byte moves when tx_valid && tx_ready at a rising edge; while
  // tx_valid is high and tx_ready low, tx_data holds and tx_valid stays high.

  localparam int WB = WIDTH / 8;
  localparam int NW = NBINS + 2;
  localparam int WW = $clog2(NW);
  localparam int BW = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(NW - 1);
  localparam logic [BW-1:0] LAST_B = BW'(WB - 1);
  localparam logic [7:0]    COUNT  = 8'(NW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_DATA,
`ifdef CLEAR_ON_READ_EN
    S_CLR,
`endif
    S_CHK
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  snap [NW];
  logic [WW-1:0]     word_idx, nxt_word;
  logic [BW-1:0]     byte_idx, nxt_byte;
  logic [7:0]        checksum;
  logic [7:0]        cur_data, nxt_data;
  logic              xfer, last_byte;

  assign dbg_state = state;

  always_comb begin
    xfer      = tx_valid && tx_ready;
    last_byte = (word_idx == LAST_W) && (byte_idx == LAST_B);
    nxt_word  = word_idx;
    nxt_byte  = byte_idx + 1'b1;
    if (byte_idx == LAST_B) begin
      nxt_byte = '0;
      if (!last_byte) nxt_word = word_idx + 1'b1;
    end
    cur_data = snap[word_idx][{byte_idx, 3'b000} +: 8];
    nxt_data = snap[nxt_word][{nxt_byte, 3'b000} +: 8];
  end

  // Snapshot register file: only written on an accepted start.
  always_ff @(posedge clkin) begin
    if (state == S_IDLE && start) begin
      snap[0] <= histo_in[WIDTH-1:0];
      snap[1] <= histo_in[2*WIDTH-1:WIDTH];
      for (int i = 0; i < NBINS; i++) snap[i+2] <= ipihist_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      resethist <= 1'b0;
      checksum  <= 8'h00;
      word_idx  <= '0;
      byte_idx  <= '0;
    end else begin
      resethist <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            checksum <= 8'h00;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_HDR: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'hA5;
          end else if (tx_ready) begin
            state   <= S_CNT;
            tx_data <= COUNT;
          end
        end
        S_CNT: begin
          if (xfer) begin
            checksum <= checksum ^ tx_data;
            tx_data  <= cur_data;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            checksum <= checksum ^ tx_data;
            if (last_byte) begin
              state   <= S_CHK;
              tx_data <= checksum ^ tx_data;
            end else begin
              word_idx <= nxt_word;
              byte_idx <= nxt_byte;
              tx_data  <= nxt_data;
            end
          end
        end
        S_CHK: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
`ifdef CLEAR_ON_READ_EN
            state     <= S_CLR;
            resethist <= 1'b1;
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef CLEAR_ON_READ_EN
        S_CLR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histo_readout.sv
// Bench for histo_readout: frames predicted from the snapshot values into a byte queue,
// a negedge monitor pops and compares every accepted byte.
module tb_histo_readout;

  localparam int NBINS = 64;
  localparam int WIDTH = 32;
  localparam int WB    = WIDTH / 8;
  localparam int NW    = NBINS + 2;
  localparam int FLEN  = 3 + NW * WB;
`ifdef CLEAR_ON_READ_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                   clkin = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [2*WIDTH-1:0]     histo_in = '0;
  logic [NBINS*WIDTH-1:0] ipihist_in = '0;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready = 1'b0;
  logic                   busy;
  logic                   resethist;
  logic [2:0]             dbg_state;

  histo_readout #(.NBINS(NBINS), .WIDTH(WIDTH)) dut (
    .clkin(clkin), .reset(reset), .start(start), .histo_in(histo_in),
    .ipihist_in(ipihist_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .resethist(resethist), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clkin = ~clkin;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  int total = 0;
  int bad = 0;
  int frame_bytes = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame as a plain byte list built from the word values.
  task automatic push_frame(input logic [2*WIDTH-1:0] h, input logic [NBINS*WIDTH-1:0] b);
    logic [WIDTH-1:0] words[NW];
    logic [7:0] cs;
    logic [7:0] bt;
    words[0] = h[WIDTH-1:0];
    words[1] = h[2*WIDTH-1:WIDTH];
    for (int i = 0; i < NBINS; i++) words[i+2] = b[i*WIDTH +: WIDTH];
    exp_q.push_back(8'hA5); exp_last_q.push_back(1'b0);
    cs = 8'(NW);
    exp_q.push_back(cs); exp_last_q.push_back(1'b0);
    for (int w = 0; w < NW; w++) begin
      for (int k = 0; k < WB; k++) begin
        bt = 8'(words[w] >> (8 * k));
        cs = cs ^ bt;
        exp_q.push_back(bt); exp_last_q.push_back(1'b0);
      end
    end
    exp_q.push_back(cs); exp_last_q.push_back(1'b1);
  endtask

  task automatic rand_vals(output logic [2*WIDTH-1:0] h, output logic [NBINS*WIDTH-1:0] b);
    for (int i = 0; i < 2; i++) h[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    for (int i = 0; i < NBINS; i++) b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // ---------------- sink ready driver ----------------
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clkin);
      #1;
      rcnt++;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (rcnt % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;
    bit prev_done = 1'b0;
    bit pend_clr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] e;
    bit l;
    forever begin
      @(negedge clkin);
      if (reset) begin
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        pend_clr   = 1'b0;
        continue;
      end
      if (resethist || pend_clr) check("resethist", resethist, CLR_EN && pend_clr);
      pend_clr = 1'b0;
      if (prev_valid && !prev_done) check("valid_continuous", tx_valid, 1);
      if (prev_valid && !prev_ready && tx_valid) check("stall_hold", tx_data, prev_data);
      prev_done = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          l = exp_last_q.pop_front();
          check("frame_byte", tx_data, e);
          frame_bytes++;
          if (l) begin
            check("frame_len", frame_bytes, FLEN);
            frame_bytes = 0;
            pend_clr    = 1'b1;
            prev_done   = 1'b1;
          end
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_start(input logic [2*WIDTH-1:0] h, input logic [NBINS*WIDTH-1:0] b, input bit chk_lat);
    int n = 0;
    while (busy) begin
      @(posedge clkin);
      #1;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL idle_wait: busy still %0d expected 0", busy);
        return;
      end
    end
    histo_in   = h;
    ipihist_in = b;
    start      = 1'b1;
    push_frame(h, b);
    @(posedge clkin);
    #1;
    start = 1'b0;
    if (chk_lat) begin
      check("busy_after_start", busy, 1);
      check("valid_one_cycle", tx_valid, 0);
      @(posedge clkin);
      #1;
      check("valid_two_cycles", tx_valid, 1);
      check("first_byte", tx_data, 8'hA5);
    end
  endtask

  task automatic run_frame(input bit scramble, input int pa, input int pb, input int rst_at);
    int cyc = 0;
    bit da = 1'b0;
    bit db = 1'b0;
    logic [2*WIDTH-1:0] h;
    logic [NBINS*WIDTH-1:0] b;
    while (exp_q.size() != 0 || busy) begin
      @(posedge clkin);
      #1;
      cyc++;
      start = 1'b0;
      if (scramble) begin
        rand_vals(h, b);
        histo_in   = h;
        ipihist_in = b;
      end
      if (pa >= 0 && !da && frame_bytes >= pa) begin start = 1'b1; da = 1'b1; end
      if (pb >= 0 && !db && frame_bytes >= pb) begin start = 1'b1; db = 1'b1; end
      if (rst_at >= 0 && frame_bytes >= rst_at) begin
        #1;
        reset = 1'b1;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_resethist", resethist, 0);
        exp_q.delete();
        exp_last_q.delete();
        frame_bytes = 0;
        @(posedge clkin);
        @(posedge clkin);
        #1;
        reset = 1'b0;
        return;
      end
      if (cyc > 4000) begin
        total++;
        bad++;
        $display("FAIL frame_timeout: %0d bytes pending expected 0", exp_q.size());
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check("done_busy", busy, 0);
    check("done_valid", tx_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2*WIDTH-1:0] h;
    logic [NBINS*WIDTH-1:0] b;

    repeat (3) @(posedge clkin);
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", tx_data, 0);
    check("rst_resethist", resethist, 0);
    reset = 1'b0;
    @(posedge clkin);
    #1;

    // Directed pattern: histo0=0x01020304, histo1=0, bin i = i.
    h = {32'h0, 32'h01020304};
    for (int i = 0; i < NBINS; i++) b[i*WIDTH +: WIDTH] = WIDTH'(i);
    ready_mode = 0;
    do_start(h, b, 1'b1);
    run_frame(1'b0, -1, -1, -1);

    // Same pattern with the sink ready one cycle in three.
    ready_mode = 1;
    do_start(h, b, 1'b0);
    run_frame(1'b0, -1, -1, -1);

    // Inputs scrambled every cycle after the snapshot.
    ready_mode = 2;
    rand_vals(h, b);
    do_start(h, b, 1'b0);
    run_frame(1'b1, -1, -1, -1);

    // start pulses while busy are dropped; a start in IDLE still works.
    ready_mode = 0;
    rand_vals(h, b);
    do_start(h, b, 1'b0);
    run_frame(1'b0, 5, 200, -1);
    rand_vals(h, b);
    do_start(h, b, 1'b1);
    run_frame(1'b0, -1, -1, -1);

    // Reset mid-frame, then a fresh complete frame.
    ready_mode = 2;
    rand_vals(h, b);
    do_start(h, b, 1'b0);
    run_frame(1'b0, -1, -1, 100);
    rand_vals(h, b);
    do_start(h, b, 1'b0);
    run_frame(1'b0, -1, -1, -1);

    // A few more random frames under random backpressure.
    for (int n = 0; n < 3; n++) begin
      rand_vals(h, b);
      do_start(h, b, 1'b0);
      run_frame(n[0], -1, -1, -1);
    end

    repeat (4) @(posedge clkin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
